// File: rtl/df_residual_pkg.sv
// Shared widths, lane-sum type and saturation bounds for the residual adder.
package df_residual_pkg;
  localparam int DEF_W = 16;

  // Lane sum one bit wider than the operands so overflow is visible.
  typedef logic signed [DEF_W:0] lane_sum_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction
endpackage

// File: rtl/df_skip_fifo.sv
// Skip-branch FIFO: registered storage, no push-through when full, head visible the cycle after push.
module df_skip_fifo
  import df_residual_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  localparam int CW   = cnt_w(DEPTH),
  localparam int AW   = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_pop_valid,
  input  logic             i_pop_ready,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  assign o_push_ready = !rst && (r_count < CW'(DEPTH));
  assign o_pop_valid  = (r_count != '0);
  assign o_pop_data   = r_mem[r_rptr];
  assign o_count      = r_count;
  assign w_push       = i_push_valid && o_push_ready;
  assign w_pop        = i_pop_ready && o_pop_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_data;
  end
endmodule

// File: rtl/df_residual_add.sv
// Residual join: skip beats queue in a FIFO and are added lane-wise to main beats in order.
// Build option DF_RESIDUAL_ADD_SATURATE_EN selects saturating lanes; default wraps.
module df_residual_add
  import df_residual_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0       = 16,
  parameter int DATA_IN_0_PRECISION_1       = 3,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int DATA_IN_1_PRECISION_0       = 16,
  parameter int DATA_IN_1_PRECISION_1       = 3,
  parameter int DATA_OUT_0_PRECISION_0      = 16,
  parameter int DATA_OUT_0_PRECISION_1      = 3,
  parameter int SKIP_FIFO_DEPTH             = 8,
  localparam int N  = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1,
  localparam int W  = DATA_IN_0_PRECISION_0,
  localparam int CW = cnt_w(SKIP_FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0][W-1:0]  data_in_0,
  input  logic                 data_in_0_valid,
  output logic                 data_in_0_ready,
  input  logic [N-1:0][W-1:0]  data_in_1,
  input  logic                 data_in_1_valid,
  output logic                 data_in_1_ready,
  output logic [N-1:0][W-1:0]  data_out_0,
  output logic                 data_out_0_valid,
  input  logic                 data_out_0_ready,
  output logic [CW-1:0]        skip_fifo_count
);
  localparam logic [W-1:0] L_MAX = W'(sat_max(W));
  localparam logic [W-1:0] L_MIN = W'(sat_min(W));

  if (DATA_IN_1_PRECISION_0 != W || DATA_OUT_0_PRECISION_0 != W ||
      DATA_IN_1_PRECISION_1 != DATA_IN_0_PRECISION_1 ||
      DATA_OUT_0_PRECISION_1 != DATA_IN_0_PRECISION_1) begin : g_bad_fmt
    $error("df_residual_add: branch formats must match");
  end

  logic [N-1:0][W-1:0] w_head, w_lanes, r_data;
  logic                w_head_vld, w_out_free, w_fire, r_vld;

  df_skip_fifo #(.WIDTH(N*W), .DEPTH(SKIP_FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push_data  (data_in_0),
    .i_push_valid (data_in_0_valid),
    .o_push_ready (data_in_0_ready),
    .o_pop_data   (w_head),
    .o_pop_valid  (w_head_vld),
    .i_pop_ready  (w_fire),
    .o_count      (skip_fifo_count)
  );

  assign w_out_free      = !r_vld || data_out_0_ready;
  assign data_in_1_ready = !rst && w_head_vld && w_out_free;
  assign w_fire          = data_in_1_ready && data_in_1_valid;

  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [W:0] w_sum;
    assign w_sum = {w_head[g][W-1], w_head[g]} + {data_in_1[g][W-1], data_in_1[g]};
`ifdef DF_RESIDUAL_ADD_SATURATE_EN
    // Top two bits disagree only when the true sum left the W-bit range.
    assign w_lanes[g] = (w_sum[W] != w_sum[W-1]) ? (w_sum[W] ? L_MIN : L_MAX) : w_sum[W-1:0];
`else
    assign w_lanes[g] = w_sum[W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (w_fire) begin
      r_vld  <= 1'b1;
      r_data <= w_lanes;
    end else if (data_out_0_ready) begin
      r_vld  <= 1'b0;
    end
  end

`ifndef DF_RESIDUAL_ADD_SATURATE_EN
  logic [2*W-1:0] w_unused_sat;
  assign w_unused_sat = {L_MAX, L_MIN};
`endif

  assign data_out_0       = r_data;
  assign data_out_0_valid = r_vld;
endmodule

// File: tb/tb_df_residual_add.sv
// Directed bench for df_residual_add: pairing, FIFO full, wrap/saturate, stall, ordering, reset.
module tb_df_residual_add;
  localparam int N = 4, W = 16, CW = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0][W-1:0] d0, d1, dout;
  logic                d0_valid, d0_ready, d1_valid, d1_ready, out_valid, out_ready;
  logic [CW-1:0]       count;

  int n_pass = 0, n_fail = 0, n_total = 0;

  always #5 clk = ~clk;

  df_residual_add dut (
    .clk              (clk),
    .rst              (rst),
    .data_in_0        (d0),
    .data_in_0_valid  (d0_valid),
    .data_in_0_ready  (d0_ready),
    .data_in_1        (d1),
    .data_in_1_valid  (d1_valid),
    .data_in_1_ready  (d1_ready),
    .data_out_0       (dout),
    .data_out_0_valid (out_valid),
    .data_out_0_ready (out_ready),
    .skip_fifo_count  (count)
  );

  function automatic logic [N-1:0][W-1:0] L(input logic [W-1:0] x);
    return {N{x}};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs change at negedge; outputs sampled at negedge after settling
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [N-1:0][W-1:0] sa, sb, exp_ab;

  initial begin
    rst = 1'b1; d0 = '0; d1 = '0; d0_valid = 1'b0; d1_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst_d0_ready", d0_ready, 0);
    chk("rst_d1_ready", d1_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", dout, 0);
    chk("rst_count", count, 0);
    rst = 1'b0; #1;
    chk("post_rst_d0_ready", d0_ready, 1);

    // fill and pair
    d0_valid = 1'b1; d0 = L(16'h0010);
    for (int i = 0; i < 3; i++) step();
    d0_valid = 1'b0; #1;
    chk("fill_count3", count, 3);
    chk("fill_no_out", out_valid, 0);
    d1_valid = 1'b1; d1 = L(16'h0020); #1;
    chk("pair_d1_ready", d1_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pair_valid", out_valid, 1);
      chk("pair_data", dout, L(16'h0030));
      chk("pair_count", count, 64'(2 - i));
    end
    d1_valid = 1'b0;
    step();
    chk("pair_drained", out_valid, 0);

    // FIFO full, then simultaneous pop with a refused 9th push
    d0_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d0 = L(16'(16'h0100 + i));
      step();
    end
    chk("full_count8", count, 8);
    chk("full_d0_ready", d0_ready, 0);
    d0 = L(16'h01FF); d1_valid = 1'b1; d1 = L(16'h0001); #1;
    chk("full_d1_ready", d1_ready, 1);
    step();
    d0_valid = 1'b0; d1_valid = 1'b0; #1;
    chk("full_pop_count7", count, 7);
    chk("full_pop_data", dout, L(16'h0101));
    d1_valid = 1'b1; d1 = L(16'h0000);
    for (int j = 1; j < 8; j++) begin
      step();
      chk("full_order", dout, L(16'(16'h0100 + j)));
    end
    d1_valid = 1'b0;
    step();
    chk("full_empty", count, 0);
    chk("full_out_idle", out_valid, 0);

    // wrap vs saturate
    sa = {16'h7000, 16'h8000, 16'h0001, 16'hFFFF};
    sb = {16'h2000, 16'hFFFF, 16'h0002, 16'hFFFF};
`ifdef DF_RESIDUAL_ADD_SATURATE_EN
    exp_ab = {16'h7FFF, 16'h8000, 16'h0003, 16'hFFFE};
`else
    exp_ab = {16'h9000, 16'h7FFF, 16'h0003, 16'hFFFE};
`endif
    d0_valid = 1'b1; d0 = sa;
    step();
    d0_valid = 1'b0; d1_valid = 1'b1; d1 = sb;
    step();
    d1_valid = 1'b0;
    chk("arith_valid", out_valid, 1);
    chk("arith_data", dout, exp_ab);
    step();
    chk("arith_drained", out_valid, 0);

    // output stall with both branches valid
    out_ready = 1'b0; d1_valid = 1'b1; d1 = L(16'h0000);
    d0_valid = 1'b1; d0 = L(16'h0001);
    step();
    d0 = L(16'h0002);
    step();
    chk("stall_first_valid", out_valid, 1);
    chk("stall_first_data", dout, L(16'h0001));
    for (int k = 0; k < 4; k++) begin
      d0 = L(16'(3 + k));
      step();
      chk("stall_hold", dout, L(16'h0001));
      chk("stall_d1_ready", d1_ready, 0);
    end
    chk("stall_count5", count, 5);
    d0_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", dout, L(16'(2 + k)));
    end
    d1_valid = 1'b0;
    step();
    chk("stream_done", out_valid, 0);
    chk("stream_empty", count, 0);

    // main before skip
    d1_valid = 1'b1; d1 = L(16'h0005); #1;
    chk("mbs_d1_ready0", d1_ready, 0);
    step();
    chk("mbs_no_out", out_valid, 0);
    d0_valid = 1'b1; d0 = L(16'h0003);
    step();
    d0_valid = 1'b0; #1;
    chk("mbs_no_bypass", out_valid, 0);
    chk("mbs_d1_ready1", d1_ready, 1);
    step();
    d1_valid = 1'b0;
    chk("mbs_valid", out_valid, 1);
    chk("mbs_data", dout, L(16'h0008));
    step();

    // mid-run reset with count 5 and an output pending
    d0_valid = 1'b1; d0 = L(16'h0011);
    for (int i = 0; i < 6; i++) step();
    d0_valid = 1'b0; d1_valid = 1'b1; d1 = L(16'h0001); out_ready = 1'b0;
    step();
    d1_valid = 1'b0;
    chk("mrst_pre_count", count, 5);
    chk("mrst_pre_valid", out_valid, 1);
    rst = 1'b1; d0_valid = 1'b1; d1_valid = 1'b1; #1;
    chk("mrst_d0_ready", d0_ready, 0);
    chk("mrst_d1_ready", d1_ready, 0);
    step();
    rst = 1'b0; d0_valid = 1'b0; d1_valid = 1'b0; out_ready = 1'b1; #1;
    chk("mrst_count", count, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", dout, 0);
    chk("mrst_d0_ready_after", d0_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/df_residual_add.md
# df_residual_add

Consumes the two branches produced by the two-way dataflow split and rejoins them as a residual connection. The skip branch (`data_in_0`) is buffered in an internal FIFO while the main branch (`data_in_1`) passes through its compute path. Matched beats are added lane-wise as signed fixed-point values, and the sum is driven from a registered valid/ready output stage.

## Interface
Parameters:
- DATA_IN_0_PRECISION_0, 16, skip-branch lane width (signed)
- DATA_IN_0_PRECISION_1, 3, skip-branch fraction bits
- DATA_IN_0_PARALLELISM_DIM_0, 4, lanes per beat, dim 0
- DATA_IN_0_PARALLELISM_DIM_1, 1, lanes per beat, dim 1
- DATA_IN_1_PRECISION_0, 16, main-branch lane width; must equal DATA_IN_0_PRECISION_0
- DATA_IN_1_PRECISION_1, 3, main-branch fraction bits; must equal DATA_IN_0_PRECISION_1
- DATA_OUT_0_PRECISION_0, 16, output lane width; must equal DATA_IN_0_PRECISION_0
- DATA_OUT_0_PRECISION_1, 3, output fraction bits; must equal DATA_IN_0_PRECISION_1
- SKIP_FIFO_DEPTH, 8, skip FIFO capacity in beats; power of two, ≥ 2

Let N = DATA_IN_0_PARALLELISM_DIM_0 × DATA_IN_0_PARALLELISM_DIM_1 and W = DATA_IN_0_PRECISION_0.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk, in, 1, sole clock; all state updates on the rising edge
  - rst, in, 1, synchronous active-high reset
- Skip-branch input:
  - data_in_0, in, W × [N], skip-branch lanes
  - data_in_0_valid, in, 1, skip beat valid
  - data_in_0_ready, out, 1, skip beat accepted when high with valid
- Main-branch input:
  - data_in_1, in, W × [N], main-branch lanes
  - data_in_1_valid, in, 1, main beat valid
  - data_in_1_ready, out, 1, main beat accepted
- Output:
  - data_out_0, out, W × [N], lane-wise sum
  - data_out_0_valid, out, 1, output beat valid
  - data_out_0_ready, in, 1, downstream accept
- Status:
  - skip_fifo_count, out, $clog2(SKIP_FIFO_DEPTH)+1, current FIFO occupancy

## Operation
- Skip push:
  - Condition: data_in_0_valid && data_in_0_ready.
  - data_in_0_ready = !rst && (count < SKIP_FIFO_DEPTH).
  - There is no push-through when the FIFO is full, even when a pop occurs in the same cycle.
- Pair fire:
  - fire = fifo_nonempty && data_in_1_valid && (!data_out_0_valid || data_out_0_ready).
  - data_in_1_ready = !rst && fifo_nonempty && (!data_out_0_valid || data_out_0_ready).
  - On fire:
    - Pop the FIFO head.
    - Accept the main beat.
    - Load the output register with the lane sums.
    - Set data_out_0_valid.
- Output drain:
  - If data_out_0_valid && data_out_0_ready && !fire, clear data_out_0_valid.
  - Data holds stable while valid is high and ready is low.
- Ordering: beats pair strictly in arrival order on both branches. No tags.
- Arithmetic:
  - Per lane: sum = sign-extend(a, W+1) + sign-extend(b, W+1).
  - Reduction to W bits follows the Configuration section.
  - Fraction bits are identical on both inputs, so no alignment shift is applied.
- Simultaneous push and pop: both apply, and count is unchanged. The read pointer advances, and so does the write pointer.
- Pointers: log2(DEPTH)-bit, wrapping modulo DEPTH. count is tracked separately.

## Timing
- Reset values:
  - data_out_0_valid = 0; data_out_0 = 0.
  - count = 0; pointers = 0.
  - Both readies are 0 while rst is high. data_in_0_ready = 1 on the first cycle after reset.
- FIFO latency:
  - A pushed beat is visible at the FIFO head on the cycle after the push.
  - There is no same-cycle bypass from data_in_0 to the adder.
- Fire-to-output latency: 1 cycle. The sum appears registered on the cycle after fire.
- Throughput: 1 beat per cycle sustained when both branches stream and downstream is always ready.
- Reset mid-operation:
  - FIFO contents are discarded.
  - Any pending output beat is dropped.
  - No beat is accepted in the reset cycle.
- Backpressure: while the output is stalled, data_in_1_ready is low. The skip FIFO continues to fill up to SKIP_FIFO_DEPTH.

## Configuration
- DF_RESIDUAL_ADD_SATURATE_EN defined:
  - Each lane saturates to [−2^(W−1), 2^(W−1)−1].
- DF_RESIDUAL_ADD_SATURATE_EN undefined:
  - Each lane wraps; the low W bits of the (W+1)-bit sum are kept.
- Handshake and latency are identical in both builds.

## Structure
- Package df_residual_pkg:
  - count/pointer width helper function
  - lane sum type
  - saturation min/max constants as functions of W
- Sub-module df_skip_fifo:
  - Parameters: width N×W and SKIP_FIFO_DEPTH.
  - Interface: push/pop valid/ready plus count.
  - Top level contains only the pairing logic, the adder/saturation, and the output register.

## Test plan
- Fill and pair: push 3 skip beats with all lanes = 0x0010, then 3 main beats with lanes = 0x0020, ready = 1.
  - Expect 3 outputs with lanes = 0x0030, each one cycle after its fire.
  - Expect skip_fifo_count to go 3 → 0.
- FIFO full: push 8 skip beats with no main traffic.
  - After the 8th, data_in_0_ready = 0 and count = 8.
  - Present a 9th skip beat and one main beat at once. The pop occurs, the 9th beat is not accepted, and count = 7 after that cycle.
- Saturate vs wrap:
  - Case 1: lanes 0x7000 + 0x2000. SATURATE_EN build gives 0x7FFF; wrap build gives 0x9000.
  - Case 2: lanes 0x8000 + 0xFFFF. Saturating build gives 0x8000; wrap build gives 0x7FFF.
- Output stall: hold data_out_0_ready = 0 for 4 cycles with both branches valid.
  - The first output beat holds stable.
  - data_in_1_ready = 0.
  - The skip FIFO continues filling.
  - On release, outputs stream at 1 beat per cycle.
- Main before skip: data_in_1_valid asserted with the FIFO empty.
  - data_in_1_ready = 0.
  - The skip beat is pushed at cycle t, the pair fires at t+1, and the output is valid at t+2.
- Mid-run reset: assert rst for 1 cycle with count = 5 and data_out_0_valid = 1.
  - Next cycle: count = 0, data_out_0_valid = 0, data_in_0_ready = 1.
